// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instruction memory and
// fills the IF/ID register with stall, redirect, flush and fault halt.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Flush,
  input  logic [31:0] Instruction,
  output logic [31:0] Address,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        AddrFault,
  output logic [31:0] FetchCount
);

  localparam logic [0:0]  ST_FETCH = 1'b0;
  localparam logic [0:0]  ST_HALT  = 1'b1;
  localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * 4);

  logic [31:0] pc, pc_n, pc_plus4;
  logic [0:0]  state, state_n;
  logic        fault_n;
  logic        bad_pc;
  logic        bubble;
  logic        capture;

  assign Address  = pc;
  assign pc_plus4 = pc + 32'd4;
  assign bad_pc   = (pc[1:0] != 2'b00) || (pc >= PC_LIMIT);

  always_comb begin
    pc_n    = pc;
    state_n = state;
    fault_n = AddrFault;
    bubble  = 1'b0;
    capture = 1'b0;
    if (state == ST_HALT) begin
      bubble = 1'b1;
      if (BranchTaken) begin
        pc_n    = BranchTarget;
        state_n = ST_FETCH;
      end
    end else begin
      if (BranchTaken) begin
        pc_n = BranchTarget;
      end else if (bad_pc) begin
        state_n = ST_HALT;
        fault_n = 1'b1;
      end else if (!Stall) begin
        pc_n = pc_plus4;
      end
      // a taken branch squashes even a stalled entry: it is wrong-path
      if (BranchTaken || Flush || bad_pc) begin
        bubble = 1'b1;
      end else if (!Stall) begin
        capture = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc                <= RESET_PC;
      state             <= ST_FETCH;
      AddrFault         <= 1'b0;
      IF_ID_Instruction <= 32'h0;
      IF_ID_PCPlus4     <= 32'h0;
      IF_ID_Valid       <= 1'b0;
      FetchCount        <= 32'h0;
    end else begin
      pc        <= pc_n;
      state     <= state_n;
      AddrFault <= fault_n;
      if (bubble) begin
        IF_ID_Instruction <= 32'h0;
        IF_ID_PCPlus4     <= 32'h0;
        IF_ID_Valid       <= 1'b0;
      end else if (capture) begin
        IF_ID_Instruction <= Instruction;
        IF_ID_PCPlus4     <= pc_plus4;
        IF_ID_Valid       <= 1'b1;
        FetchCount        <= FetchCount + 32'd1;
      end
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage of the single-issue MIPS datapath: the requester side of `InstructionMemory`. It owns the program counter and drives `Address` to the combinational instruction memory. It captures the returned `Instruction` into the IF/ID pipeline register and handles stall, branch redirect, flush and address-fault halt.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `MEM_WORDS`, default 128: instruction memory depth in words. Legal PC range is 0 .. MEM_WORDS*4-4.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state immediately.
- `Stall`, input, 1: hold PC and IF/ID contents.
- `BranchTaken`, input, 1: redirect fetch to `BranchTarget`.
- `BranchTarget`, input, 32: redirect byte address.
- `Flush`, input, 1: insert a bubble into IF/ID.
- `Instruction`, input, 32: word returned by instruction memory, combinational and valid in the same cycle as `Address`.
- `Address`, output, 32: current PC, driven directly from the PC register.
- `IF_ID_Instruction`, output, 32: captured instruction; NOP (32'h0) when invalid.
- `IF_ID_PCPlus4`, output, 32: PC+4 of the captured instruction; 0 when invalid.
- `IF_ID_Valid`, output, 1: IF/ID holds a real instruction.
- `AddrFault`, output, 1: sticky; a fetch address was misaligned or out of range.
- `FetchCount`, output, 32: number of instructions captured with Valid=1; wraps modulo 2^32.

## Operation
- States:
  - `FETCH`: normal operation.
  - `HALT`: entered on a fault.
- Fault condition, evaluated on the current PC: `PC[1:0] != 0` or `PC >= MEM_WORDS*4`.
- Next-PC priority in `FETCH`, highest first:
  1. `BranchTaken` → `BranchTarget`.
  2. Fault → PC unchanged; state → `HALT`; `AddrFault` ← 1.
  3. `Stall` → PC unchanged.
  4. Otherwise → PC+4. 32-bit add, wraps at 2^32.
- IF/ID update priority, highest first:
  1. `BranchTaken` or `Flush` → Valid=0, Instruction=0, PCPlus4=0.
  2. Fault → bubble, same values as above.
  3. `Stall` → hold all three registers.
  4. Otherwise → capture `Instruction`, PC+4, Valid=1; `FetchCount` += 1.
- `BranchTaken` wins over `Stall`: the stalled IF/ID entry is wrong-path and is squashed.
- `Flush` without `BranchTaken` squashes IF/ID. PC still follows `Stall` or increment.
- `HALT` behaviour:
  - PC frozen; IF/ID forced to bubble every cycle; `FetchCount` frozen.
  - `Stall` and `Flush` are ignored.
  - `BranchTaken` loads `BranchTarget` and returns the state to `FETCH`.
  - `AddrFault` remains 1 until `reset`.
- A misaligned `BranchTarget` is accepted into PC and faults in the following cycle.
- `Address` always equals PC, including in `HALT`. Memory reads have no side effects.

## Timing
- Reset values: PC=`RESET_PC`, `Address`=`RESET_PC`, `IF_ID_Instruction`=0, `IF_ID_PCPlus4`=0, `IF_ID_Valid`=0, `AddrFault`=0, `FetchCount`=0, state `FETCH`.
- Reset asserted mid-operation clears everything asynchronously. There is no partial capture on the deassertion edge.
- Latency:
  - `Address` → IF/ID is one cycle: the word at PC is visible on IF/ID outputs after the next rising edge.
  - Branch penalty is one bubble: the target instruction appears on IF/ID two edges after the `BranchTaken` edge.
- Throughput: one instruction per cycle when no stall, flush, branch or fault is active.
- Last legal fetch is PC=MEM_WORDS*4-4. It is captured normally, PC advances to MEM_WORDS*4, and the fault is raised on the next edge.
- `AddrFault` rises on the same edge that enters `HALT`.

## Test plan
Memory preload: word0=32'h014B4820, word1=32'h8D490004, word2=32'hAD490004, word3=32'h112A0003.

1. Straight-line fetch:
   - Stimulus: release reset, 4 clocks.
   - Required: IF/ID shows 014B4820/4, 8D490004/8, AD490004/C, 112A0003/10, all Valid=1; `FetchCount`=4.
2. Stall:
   - Stimulus: assert `Stall` for 2 cycles while IF/ID=8D490004.
   - Required: `Address` holds 32'h8; IF/ID holds 8D490004/8; `FetchCount` unchanged. AD490004 appears on the first edge after `Stall` drops.
3. Branch over stall:
   - Stimulus: `BranchTaken`=1, `Stall`=1, `BranchTarget`=32'h0 while PC=32'hC.
   - Required: next cycle Valid=0 and `Address`=0; one edge later IF/ID=014B4820/4.
4. Fault on out-of-range:
   - Stimulus: run from PC=32'h1FC with `MEM_WORDS`=128.
   - Required: word 127 captured; PC=32'h200; next edge `AddrFault`=1, Valid=0, PC stays 32'h200, `FetchCount` frozen.
5. Misaligned target and recovery:
   - Stimulus: `BranchTarget`=32'h6; then `BranchTaken` to 32'h4 while in `HALT`.
   - Required: fault one cycle after the branch; recovery fetches 8D490004; `AddrFault` stays 1.
6. Async reset mid-stream:
   - Stimulus: assert `reset` between edges while Valid=1.
   - Required: all outputs reach their reset values before the next edge.
